// File: rtl/sprite_blitter.sv
// Sprite blitter: copies an SPR_W x SPR_H sprite from ROM into the frame buffer at
// (dst_x, dst_y), skipping transparent and off-screen pixels, writing only during vblank.
module sprite_blitter #(
    parameter int unsigned SPR_W = 32,
    parameter int unsigned SPR_H = 32,
    parameter int unsigned FB_W  = 160,
    parameter int unsigned FB_H  = 120,
    parameter logic [11:0] KEY   = 12'hF0F
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [7:0]  dst_x,
    input  logic [6:0]  dst_y,
    input  logic        vblank,
    output logic [9:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [14:0] fb_addr,
    output logic [11:0] fb_data,
    output logic        fb_we,
    output logic        busy,
    output logic        done
);

    localparam int unsigned SX_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned SY_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int unsigned SUM_W = 16;
    localparam logic [SX_W-1:0] SX_LAST = SX_W'(SPR_W - 1);
    localparam logic [SY_W-1:0] SY_LAST = SY_W'(SPR_H - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [SX_W-1:0] sx_q, sx_d;
    logic [SY_W-1:0] sy_q, sy_d;
    logic [7:0]      dx_q, dx_d;
    logic [6:0]      dy_q, dy_d;

    logic [SUM_W-1:0] px, py;
    logic             clip;
    logic             transparent;
    logic             in_write;
    logic             unused_rom_hi;

    // State, counters and latched destination
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            sx_q    <= '0;
            sy_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
        end else begin
            state_q <= state_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
        end
    end

    // Next-state and counter advance
    always_comb begin
        state_d = state_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dx_d    = dst_x;
                    dy_d    = dst_y;
                    sx_d    = '0;
                    sy_d    = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (vblank) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (vblank) begin
                    if (sx_q != SX_LAST) begin
                        sx_d    = sx_q + SX_W'(1);
                        state_d = S_READ;
                    end else if (sy_q != SY_LAST) begin
                        sx_d    = '0;
                        sy_d    = sy_q + SY_W'(1);
                        state_d = S_READ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                sx_d    = '0;
                sy_d    = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Destination sums are 16 bits so off-screen coordinates never wrap back on-screen
    assign px          = SUM_W'(dx_q) + SUM_W'(sx_q);
    assign py          = SUM_W'(dy_q) + SUM_W'(sy_q);
    assign clip        = (32'(px) >= FB_W) || (32'(py) >= FB_H);
    assign transparent = (rom_data[11:0] == KEY);
    assign in_write    = (state_q == S_WRITE);

    assign rom_addr = 10'(32'(sy_q) * SPR_W + 32'(sx_q));
    assign fb_addr  = in_write ? 15'(32'(py) * FB_W + 32'(px)) : '0;
    assign fb_data  = in_write ? rom_data[11:0] : '0;
    assign fb_we    = in_write && vblank && !clip && !transparent;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

    assign unused_rom_hi = ^rom_data[15:12];

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a 4x4 sprite and a registered index ROM.
module tb_sprite_blitter;

    logic        clk;
    logic        clr;
    logic        start;
    logic [7:0]  dst_x;
    logic [6:0]  dst_y;
    logic        vblank;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data;
    logic [14:0] fb_addr;
    logic [11:0] fb_data;
    logic        fb_we;
    logic        busy;
    logic        done;

    logic [15:0] rom [0:15];

    int vectors;
    int miscompares;

    int wr_addr [$];
    int wr_data [$];
    int gap_rom [$];
    int gap_we  [$];
    int lat;
    bit timed_out;

    sprite_blitter #(.SPR_W(4), .SPR_H(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .dst_x    (dst_x),
        .dst_y    (dst_y),
        .vblank   (vblank),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_we    (fb_we),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous sprite ROM: data one clock after address
    always @(posedge clk) rom_data <= rom[rom_addr[3:0]];

    // Drive one blit and record writes, latency and samples taken while vblank is low
    task automatic run_blit(input int x, input int y, input int gap_at, input int gap_len,
                            input int restart_at);
        int  cyc;
        bit  in_gap;
        wr_addr.delete();
        wr_data.delete();
        gap_rom.delete();
        gap_we.delete();
        lat       = 0;
        timed_out = 1'b0;
        @(posedge clk); #1;
        dst_x  = 8'(x);
        dst_y  = 7'(y);
        start  = 1'b1;
        vblank = 1'b1;
        cyc    = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == restart_at);
            if (cyc == restart_at) begin
                dst_x = 8'd0;
                dst_y = 7'd0;
            end
            in_gap = (gap_len > 0) && (cyc >= gap_at) && (cyc < gap_at + gap_len);
            vblank = !in_gap;
            @(negedge clk);
            if (in_gap) begin
                gap_rom.push_back(int'(rom_addr));
                gap_we.push_back(int'(fb_we));
            end
            if (fb_we === 1'b1) begin
                wr_addr.push_back(int'(fb_addr));
                wr_data.push_back(int'(fb_data));
            end
            if (done === 1'b1) begin
                lat = cyc;
                break;
            end
            if (cyc >= 300) begin
                timed_out = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        start  = 1'b0;
        vblank = 1'b1;
    endtask

    task automatic test_reset;
        clr = 1'b0; start = 1'b0; vblank = 1'b1; dst_x = 8'd0; dst_y = 7'd0;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b expected 0", done); end
        vectors++; if (fb_we !== 1'b0) begin miscompares++; $display("FAIL reset_fb_we: got %0b expected 0", fb_we); end
        vectors++; if (rom_addr !== 10'd0) begin miscompares++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
        vectors++; if (fb_addr !== 15'd0) begin miscompares++; $display("FAIL reset_fb_addr: got %0d expected 0", fb_addr); end
        vectors++; if (fb_data !== 12'd0) begin miscompares++; $display("FAIL reset_fb_data: got %0d expected 0", fb_data); end
        @(posedge clk); #1;
        clr = 1'b1;
    endtask

    task automatic test_basic;
        run_blit(10, 20, 0, 0, -1);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL basic_timeout: got 1 expected 0"); end
        vectors++; if (lat != 33) begin miscompares++; $display("FAIL basic_latency: got %0d expected 33", lat); end
        vectors++; if (wr_addr.size() != 16) begin miscompares++; $display("FAIL basic_count: got %0d expected 16", wr_addr.size()); end
        if (wr_addr.size() == 16) begin
            vectors++; if (wr_addr[0] != 3210) begin miscompares++; $display("FAIL basic_first: got %0d expected 3210", wr_addr[0]); end
            vectors++; if (wr_addr[15] != 3693) begin miscompares++; $display("FAIL basic_last: got %0d expected 3693", wr_addr[15]); end
            for (int i = 0; i < 16; i++) begin
                vectors++;
                if (wr_addr[i] != (20 + i / 4) * 160 + 10 + i % 4 || wr_data[i] != i) begin
                    miscompares++;
                    $display("FAIL basic_pixel%0d: got addr %0d data %0d expected addr %0d data %0d",
                             i, wr_addr[i], wr_data[i], (20 + i / 4) * 160 + 10 + i % 4, i);
                end
            end
        end
    endtask

    task automatic test_transparent;
        bit hit;
        rom[5] = 16'hAF0F;
        run_blit(10, 20, 0, 0, -1);
        hit = 1'b0;
        foreach (wr_addr[i]) if (wr_addr[i] == 3371) hit = 1'b1;
        vectors++; if (wr_addr.size() != 15) begin miscompares++; $display("FAIL key_count: got %0d expected 15", wr_addr.size()); end
        vectors++; if (hit) begin miscompares++; $display("FAIL key_skip: got write at 3371 expected none"); end
        vectors++; if (lat != 33) begin miscompares++; $display("FAIL key_latency: got %0d expected 33", lat); end
        rom[5] = 16'h0005;
    endtask

    task automatic test_clip;
        int exp_a [4];
        int exp_d [4];
        exp_a = '{19038, 19039, 19198, 19199};
        exp_d = '{0, 1, 4, 5};
        run_blit(158, 118, 0, 0, -1);
        vectors++; if (wr_addr.size() != 4) begin miscompares++; $display("FAIL clip_count: got %0d expected 4", wr_addr.size()); end
        vectors++; if (lat != 33) begin miscompares++; $display("FAIL clip_done: got latency %0d expected 33", lat); end
        if (wr_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (wr_addr[i] != exp_a[i] || wr_data[i] != exp_d[i]) begin
                    miscompares++;
                    $display("FAIL clip_pixel%0d: got addr %0d data %0d expected addr %0d data %0d",
                             i, wr_addr[i], wr_data[i], exp_a[i], exp_d[i]);
                end
            end
        end
        // Sums past 255/127 must not wrap onto row/column 0
        run_blit(255, 127, 0, 0, -1);
        vectors++; if (wr_addr.size() != 0) begin miscompares++; $display("FAIL clip_nowrap: got %0d writes expected 0", wr_addr.size()); end
        vectors++; if (lat != 33) begin miscompares++; $display("FAIL clip_nowrap_done: got latency %0d expected 33", lat); end
    endtask

    task automatic test_vblank_gap;
        run_blit(10, 20, 12, 10, -1);
        vectors++; if (lat != 43) begin miscompares++; $display("FAIL gap_latency: got %0d expected 43", lat); end
        vectors++; if (gap_rom.size() != 10) begin miscompares++; $display("FAIL gap_samples: got %0d expected 10", gap_rom.size()); end
        foreach (gap_rom[i]) begin
            vectors++;
            if (gap_rom[i] != 5 || gap_we[i] != 0) begin
                miscompares++;
                $display("FAIL gap_hold%0d: got rom_addr %0d fb_we %0d expected rom_addr 5 fb_we 0", i, gap_rom[i], gap_we[i]);
            end
        end
        vectors++; if (wr_addr.size() != 16) begin miscompares++; $display("FAIL gap_count: got %0d expected 16", wr_addr.size()); end
        if (wr_addr.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                vectors++;
                if (wr_addr[i] != (20 + i / 4) * 160 + 10 + i % 4 || wr_data[i] != i) begin
                    miscompares++;
                    $display("FAIL gap_pixel%0d: got addr %0d data %0d expected addr %0d data %0d",
                             i, wr_addr[i], wr_data[i], (20 + i / 4) * 160 + 10 + i % 4, i);
                end
            end
        end
        // Stall entered from READ of pixel 6
        run_blit(10, 20, 13, 3, -1);
        vectors++; if (lat != 36) begin miscompares++; $display("FAIL gap_read_latency: got %0d expected 36", lat); end
        foreach (gap_rom[i]) begin
            vectors++;
            if (gap_rom[i] != 6 || gap_we[i] != 0) begin
                miscompares++;
                $display("FAIL gap_read_hold%0d: got rom_addr %0d fb_we %0d expected rom_addr 6 fb_we 0", i, gap_rom[i], gap_we[i]);
            end
        end
        vectors++; if (wr_addr.size() != 16) begin miscompares++; $display("FAIL gap_read_count: got %0d expected 16", wr_addr.size()); end
    endtask

    task automatic test_back_to_back;
        run_blit(10, 20, 0, 0, 5);
        vectors++; if (lat != 33) begin miscompares++; $display("FAIL busy_start_latency: got %0d expected 33", lat); end
        vectors++; if (wr_addr.size() != 16) begin miscompares++; $display("FAIL busy_start_count: got %0d expected 16", wr_addr.size()); end
        if (wr_addr.size() == 16) begin
            vectors++; if (wr_addr[15] != 3693) begin miscompares++; $display("FAIL busy_start_last: got %0d expected 3693", wr_addr[15]); end
        end
        run_blit(10, 20, 0, 0, 33);
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL done_start_busy: got %0b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_pulse_width: got %0b expected 0", done); end
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        dst_x = 8'd10; dst_y = 7'd20; start = 1'b1; vblank = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_reset_busy: got %0b expected 0", busy); end
        vectors++; if (fb_we !== 1'b0) begin miscompares++; $display("FAIL mid_reset_fb_we: got %0b expected 0", fb_we); end
        vectors++; if (rom_addr !== 10'd0) begin miscompares++; $display("FAIL mid_reset_rom_addr: got %0d expected 0", rom_addr); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (fb_we !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_reset_hold%0d: got fb_we %0b busy %0b expected 0 0", i, fb_we, busy);
            end
        end
        @(posedge clk); #1;
        clr = 1'b1;
        run_blit(10, 20, 0, 0, -1);
        vectors++; if (wr_addr.size() != 16) begin miscompares++; $display("FAIL mid_restart_count: got %0d expected 16", wr_addr.size()); end
        vectors++; if (lat != 33) begin miscompares++; $display("FAIL mid_restart_latency: got %0d expected 33", lat); end
        if (wr_addr.size() > 0) begin
            vectors++;
            if (wr_addr[0] != 3210 || wr_data[0] != 0) begin
                miscompares++;
                $display("FAIL mid_restart_first: got addr %0d data %0d expected addr 3210 data 0", wr_addr[0], wr_data[0]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 16; i++) rom[i] = 16'(i);
        test_reset();
        test_basic();
        test_transparent();
        test_clip();
        test_vblank_gap();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameters SHALL be: SPR_W, default 32, sprite width in pixels; SPR_H, default 32, sprite height; FB_W, default 160, frame-buffer width; FB_H, default 120, frame-buffer height; KEY, default 12'hF0F, transparent colour.
REQ-002 clk  input  1  system clock; all state SHALL change on the rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle request to begin a blit.
REQ-005 dst_x  input  8  destination column of sprite pixel (0,0).
REQ-006 dst_y  input  7  destination row of sprite pixel (0,0).
REQ-007 vblank  input  1  level; high while the display is not scanning the frame buffer.
REQ-008 rom_addr  output  10  sprite ROM address, row-major, sy*SPR_W+sx.
REQ-009 rom_data  input  16  sprite ROM data, valid one clk after rom_addr; [11:0] = {blue,green,red}, [15:12] ignored.
REQ-010 fb_addr  output  15  frame-buffer write address, (dst_y+sy)*FB_W+(dst_x+sx).
REQ-011 fb_data  output  12  frame-buffer write data.
REQ-012 fb_we  output  1  frame-buffer write enable, one pixel per asserted cycle.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when the blit completes.

Function
REQ-015 The FSM SHALL have the states IDLE, READ, WRITE and DONE.
REQ-016 In IDLE, start=1 SHALL latch dst_x and dst_y, clear sx and sy, and enter READ; start in any other state SHALL be ignored.
REQ-017 In READ, rom_addr SHALL present sy*SPR_W+sx.
  - vblank=1: go to WRITE next cycle.
  - vblank=0: stay in READ, rom_addr held.
REQ-018 In WRITE with vblank=0, the block SHALL stay in WRITE with fb_we=0, holding rom_addr and the counters.
REQ-019 In WRITE with vblank=1, the block SHALL:
  - drive fb_addr and fb_data=rom_data[11:0];
  - assert fb_we unless the pixel is clipped or transparent;
  - advance the counters.
REQ-020 A pixel is transparent when rom_data[11:0]==KEY; it is clipped when dst_x+sx>=FB_W or dst_y+sy>=FB_H.
  - Both cases: fb_we=0, but the counters still advance.
REQ-021 Destination sums and fb_addr SHALL be computed at least 16 bits wide, with no wrap before the clip compare.
REQ-022 Counter advance SHALL be:
  - sx<SPR_W-1: sx+1, back to READ.
  - sx==SPR_W-1 and sy<SPR_H-1: sx=0, sy+1, back to READ.
  - last pixel: go to DONE.
REQ-023 DONE SHALL last one cycle with done=1 and busy=1, then return to IDLE; a start in that cycle SHALL be ignored.
REQ-024 Minimum blit latency with vblank held high SHALL be 2*SPR_W*SPR_H+1 cycles from start to done.
REQ-025 fb_we SHALL be 0 outside WRITE, and fb_addr/fb_data SHALL be don't-care when fb_we=0.

Reset
REQ-026 While clr=0, the outputs SHALL be:
  - state=IDLE, sx=sy=0;
  - busy=0, done=0, fb_we=0;
  - rom_addr=0, fb_addr=0, fb_data=0.
REQ-027 Reset mid-blit SHALL abandon the blit with no further writes; after clr=1, the first start SHALL begin a fresh blit.

Verification
REQ-028 Scenario 1: vblank=1, SPR_W=SPR_H=4, ROM=index, start with dst=(10,20).
  - Expect 16 writes, first fb_addr=20*160+10=3210, last 23*160+13=3693.
  - Expect done 33 cycles after start.
REQ-029 Scenario 2: ROM word 5 = 16'hAF0F (upper nibble ignored).
  - Expect no write at that pixel.
  - Expect 15 writes total.
REQ-030 Scenario 3: dst=(158,118), 4x4 sprite.
  - Expect only the 4 pixels at sx<2, sy<2 written: addresses 19038, 19039, 19198, 19199.
  - Expect done still pulsed.
REQ-031 Scenario 4: vblank low for 10 cycles mid-blit.
  - Expect fb_we=0 and rom_addr frozen during the gap.
  - Expect the write sequence to resume without skipping or repeating a pixel.
  - Expect done delayed by exactly 10 cycles.
REQ-032 Scenario 5: start pulsed again while busy.
  - Expect it ignored.
REQ-033 Scenario 6: clr=0 asserted at pixel 7.
  - Expect busy=0 and fb_we=0 immediately.
  - Expect a new start to rewrite from pixel 0.
